// File: rtl/gamma_cycle_sequencer.sv
// gamma_cycle_sequencer: steps the race-logic primitive array through SET, EVAL and CAPTURE phases for a counted or continuous run
module gamma_cycle_sequencer #(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int SET_WIDTH         = 1,
    parameter int CNT_W             = 16,
    localparam int TW               = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic             aclk,
    input  logic             grst,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] cfg_cycles,
    output logic             set,
    output logic             eval,
    output logic             capture,
    output logic [TW-1:0]    gamma_tick,
    output logic [CNT_W-1:0] cycle_count,
    output logic             busy,
    output logic             done
);
    if (GAMMA_CYCLE_WIDTH < SET_WIDTH + PULSE_WIDTH + 2) begin : g_bad_cfg
        $error("GAMMA_CYCLE_WIDTH too small for SET_WIDTH + PULSE_WIDTH + 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_SET, S_EVAL, S_CAPTURE, S_DONE} state_t;

    state_t           state, state_n;
    logic [TW-1:0]    tick_n;
    logic [CNT_W-1:0] cnt_n, cnt_inc, cfg, cfg_n;
    logic             stop_pend, stop_n;

    assign cnt_inc = &cycle_count ? cycle_count : cycle_count + CNT_W'(1);

    always_comb begin
        state_n = state;
        tick_n  = gamma_tick;
        cnt_n   = cycle_count;
        cfg_n   = cfg;
        stop_n  = stop_pend;
        case (state)
            S_IDLE: if (start && !stop) begin
                state_n = S_SET;
                cfg_n   = cfg_cycles;
                cnt_n   = '0;
                stop_n  = 1'b0;
            end
            S_SET: begin
                tick_n  = gamma_tick + TW'(1);
                stop_n  = stop_pend | stop;
                state_n = gamma_tick == TW'(SET_WIDTH - 1) ? S_EVAL : S_SET;
            end
            S_EVAL: begin
                tick_n  = gamma_tick + TW'(1);
                stop_n  = stop_pend | stop;
                state_n = gamma_tick == TW'(GAMMA_CYCLE_WIDTH - 2) ? S_CAPTURE : S_EVAL;
            end
            S_CAPTURE: begin
                tick_n  = '0;
                cnt_n   = cnt_inc;
                stop_n  = stop_pend | stop;
                // a stop seen during this very capture still ends the run here
                state_n = (stop_pend || stop || (cfg != '0 && cnt_inc == cfg)) ? S_DONE : S_SET;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // phase outputs are registered from the next state so they never glitch
    always_ff @(posedge aclk or posedge grst) begin
        if (grst) begin
            state       <= S_IDLE;
            gamma_tick  <= '0;
            cycle_count <= '0;
            cfg         <= '0;
            stop_pend   <= 1'b0;
            set         <= 1'b0;
            eval        <= 1'b0;
            capture     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            gamma_tick  <= tick_n;
            cycle_count <= cnt_n;
            cfg         <= cfg_n;
            stop_pend   <= stop_n;
            set         <= state_n == S_SET;
            eval        <= state_n == S_EVAL;
            capture     <= state_n == S_CAPTURE;
            busy        <= state_n != S_IDLE;
            done        <= state_n == S_DONE;
        end
    end
endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
// tb_gamma_cycle_sequencer: scoreboard bench comparing per-tick phase outputs against expected gamma-cycle traces
module tb_gamma_cycle_sequencer;
    localparam int G  = 16;
    localparam int P  = 8;
    localparam int SW = 2;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          grst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] cfg_cycles = '0;
    logic          set, eval, capture, busy, done;
    logic [3:0]    gamma_tick;
    logic [CW-1:0] cycle_count;

    int            errors = 0;
    int            checks = 0;
    logic [24:0]   exp_q[$];

    always #5 aclk = ~aclk;

    gamma_cycle_sequencer #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH(P),
        .SET_WIDTH(SW),
        .CNT_W(CW)
    ) dut (
        .aclk(aclk),
        .grst(grst),
        .start(start),
        .stop(stop),
        .cfg_cycles(cfg_cycles),
        .set(set),
        .eval(eval),
        .capture(capture),
        .gamma_tick(gamma_tick),
        .cycle_count(cycle_count),
        .busy(busy),
        .done(done)
    );

    function automatic logic [24:0] obs();
        return {set, eval, capture, busy, done, gamma_tick, cycle_count};
    endfunction

    function automatic logic [24:0] mk(logic s, logic e, logic c, logic b, logic d, int t, int n);
        return {s, e, c, b, d, 4'(t), 16'(n)};
    endfunction

    task automatic chk(string tag, logic [24:0] got, logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // expected trace: ncyc full gamma cycles, then done, then two idle ticks
    task automatic push_run(int ncyc, int total);
        for (int i = 0; i < ncyc; i++)
            for (int t = 0; t < G; t++)
                exp_q.push_back(mk(t < SW, t >= SW && t < G - 1, t == G - 1, 1'b1, 1'b0, t, i));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, total));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, total));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, total));
    endtask

    task automatic step(string tag);
        logic [24:0] e;
        @(posedge aclk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        e = exp_q.pop_front();
        chk(tag, obs(), e);
        if (busy && !done)
            chk({tag, "_onehot"}, 25'(int'(set) + int'(eval) + int'(capture)), 25'd1);
    endtask

    task automatic drain(string tag, int stop_at, int restart_at, int limit);
        for (int j = 0; j < limit && exp_q.size() > 0; j++) begin
            step(tag);
            if (j == stop_at) stop = 1'b1;
            if (j == restart_at) begin
                start      = 1'b1;
                cfg_cycles = 16'd7;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge aclk);
        #1;
        chk("reset", obs(), 25'd0);
        grst = 1'b0;

        cfg_cycles = 16'd3;
        start = 1'b1;
        push_run(3, 3);
        drain("cfg3", -1, -1, 1000);

        cfg_cycles = 16'd0;
        start = 1'b1;
        push_run(5, 5);
        drain("cont_stop", 4 * G + 7, -1, 1000);

        cfg_cycles = 16'd2;
        start = 1'b1;
        push_run(2, 2);
        drain("restart_ignored", -1, 5, 1000);

        start = 1'b1;
        stop  = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2));
        drain("start_stop_idle", -1, -1, 1000);

        cfg_cycles = 16'd4;
        start = 1'b1;
        push_run(1, 1);
        drain("stop_in_capture", G - 1, -1, 1000);

        cfg_cycles = 16'd0;
        start = 1'b1;
        push_run(2, 0);
        drain("pre_reset", -1, -1, G + 10);
        exp_q.delete();
        #2 grst = 1'b1;
        #1 chk("async_reset", obs(), 25'd0);
        repeat (3) begin
            @(posedge aclk);
            #1 chk("reset_hold", obs(), 25'd0);
        end
        grst = 1'b0;

        cfg_cycles = 16'd1;
        start = 1'b1;
        push_run(1, 1);
        drain("single", -1, -1, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gamma_cycle_sequencer.md
Name: gamma_cycle_sequencer

Overview:
Sequences gamma cycles for the temporal (race-logic) primitive array: greater-than, min/max and pulse-width comparators.
- Per gamma cycle: issues the `set` pulse that arms the primitives' SR latches, opens an evaluation window, then strobes a capture at cycle end.
- Counts completed gamma cycles and runs either a configured count or continuously until stopped.
- Sits between the top-level run control and the primitive array; drives every primitive's `set` input in lockstep.

Parameters:
GAMMA_CYCLE_WIDTH, 16, total aclk ticks per gamma cycle (SET + EVAL + CAPTURE)
PULSE_WIDTH, 8, pulse width in ticks used by pulse-encoded primitives; constrains the EVAL length
SET_WIDTH, 1, ticks `set` is held high at start of each gamma cycle
CNT_W, 16, width of cycle count and configuration

Ports:
aclk  in  1  clock
grst  in  1  reset
start  in  1  request to begin a run; sampled only in IDLE
stop  in  1  request to end a run after the current gamma cycle completes
cfg_cycles  in  CNT_W  number of gamma cycles to run; 0 means continuous; latched when start is accepted
set  out  1  arming pulse to primitives; high during SET phase
eval  out  1  high during EVAL phase; upstream drives spike/edge inputs only while high
capture  out  1  one-tick strobe in final tick of each gamma cycle; downstream samples primitive outputs
gamma_tick  out  $clog2(GAMMA_CYCLE_WIDTH)  tick index within current gamma cycle
cycle_count  out  CNT_W  completed gamma cycles in current/last run
busy  out  1  high in any state other than IDLE
done  out  1  one-tick pulse when a run ends

Behaviour:
- Reset: grst is asynchronous and active-high; clock is aclk.
  - On grst, all outputs go to 0 immediately, state goes to IDLE, and the latched cfg and stop-pending flag clear.
  - grst mid-run aborts the run with no done pulse.
- Elaboration assertion: GAMMA_CYCLE_WIDTH >= SET_WIDTH + PULSE_WIDTH + 2.
- States: IDLE, SET, EVAL, CAPTURE, DONE.
- IDLE:
  - start=1 and stop=0 at an edge: latch cfg_cycles, clear cycle_count to 0, clear stop-pending, go to SET. `set` is high from the following tick.
  - start and stop both high: ignored, stay IDLE.
- SET:
  - Occupies gamma_tick 0..SET_WIDTH-1; set=1.
  - After the last SET tick, go to EVAL.
- EVAL:
  - Occupies gamma_tick SET_WIDTH..GAMMA_CYCLE_WIDTH-2; eval=1.
  - After tick GAMMA_CYCLE_WIDTH-2, go to CAPTURE.
- CAPTURE:
  - Single tick at gamma_tick GAMMA_CYCLE_WIDTH-1; capture=1.
  - cycle_count increments on exiting CAPTURE and saturates at all-ones.
  - Next state:
    - DONE if stop-pending, or if cfg!=0 and the incremented count equals cfg.
    - Otherwise SET, with gamma_tick wrapping to 0 and no idle gap between gamma cycles.
- DONE: one tick, done=1, busy=1; next state IDLE.
- gamma_tick:
  - Increments every tick in SET/EVAL/CAPTURE and wraps GAMMA_CYCLE_WIDTH-1 -> 0.
  - Held at 0 in IDLE/DONE.
- stop:
  - Accepted in SET/EVAL/CAPTURE; sets stop-pending.
  - A stop that arrives in CAPTURE still ends the run after that same CAPTURE.
  - The current gamma cycle always completes in full (capture is never skipped).
- start while busy is ignored; cfg_cycles changes while busy have no effect.
- set, eval and capture are mutually exclusive and decoded registered from state, so they are glitch-free.
- cycle_count holds its value in IDLE until the next accepted start.

Test Plan:
(Defaults G=16, P=8, SET_WIDTH=2.)
1. cfg_cycles=3, pulse start once → busy rises next tick; 48 run ticks follow:
   - per gamma cycle: set high 2 ticks, eval high 13 ticks, capture high 1 tick at gamma_tick=15.
   - after the 48 run ticks: done pulses 1 tick, then IDLE with cycle_count=3.
2. cfg_cycles=0, assert stop at gamma_tick=7 of the 5th gamma cycle → that cycle's capture still fires; cycle_count=5; done pulses; no further set.
3. grst asserted mid-EVAL (gamma_tick=9, cycle 2) → set/eval/capture/busy/cycle_count go to 0 immediately, no done; a later start restarts from gamma_tick 0 with cycle_count 0.
4. start re-pulsed during a cfg_cycles=2 run with cfg_cycles input changed to 7 → run still ends after 2 cycles.
5. start and stop both high in IDLE → remains IDLE, busy=0; stop pulsed exactly in CAPTURE of cycle 1 with cfg_cycles=4 → DONE follows immediately, cycle_count=1.
6. cfg_cycles=1 → set/eval/capture pattern exactly once, then done; at every tick exactly one of set/eval/capture is high while in SET/EVAL/CAPTURE.
